oserdes_load_ctrl: RTL and testbench

OSERDES_LOAD_CTRL -- requirements
Module: oserdes_load_ctrl

---
 rtl/oserdes_ctrl_pkg.sv | 30 +++
 rtl/oserdes_load_ctrl_if.sv | 40 ++++
 rtl/sync_2ff.sv | 24 ++
 rtl/oserdes_load_ctrl.sv | 155 +++++++++++++++
 tb/tb_oserdes_load_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/oserdes_ctrl_pkg.sv
// Shared definitions for the OSERDES load controller: FSM state encoding,
// parameter range limits and small helpers.
package oserdes_ctrl_pkg;

  localparam int unsigned WidthMin      = 3;
  localparam int unsigned WidthMax      = 10;
  localparam int unsigned LockSettleMin = 1;
  localparam int unsigned LockSettleMax = 255;
  localparam int unsigned RstCyclesMin  = 1;
  localparam int unsigned RstCyclesMax  = 15;
  localparam int unsigned LoadPeriodMin = 1;
  localparam int unsigned LoadPeriodMax = 16;

  localparam int unsigned SettleCntW = 8;
  localparam int unsigned RstCntW    = 4;
  localparam int unsigned PeriodCntW = 5;
  localparam int unsigned UnderrunW  = 8;

  typedef logic [1:0] state_t;

  localparam state_t StWaitLock = 2'd0;
  localparam state_t StSettle   = 2'd1;
  localparam state_t StSrst     = 2'd2;
  localparam state_t StRun      = 2'd3;

  function automatic logic [UnderrunW-1:0] sat_inc(input logic [UnderrunW-1:0] v);
    return (v == {UnderrunW{1'b1}}) ? v : v + {{(UnderrunW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/oserdes_load_ctrl_if.sv
// Word stream and O_SERDES control bundle between user logic, the load
// controller and the SERDES primitive.
interface oserdes_load_ctrl_if #(
  parameter int unsigned WIDTH = 4
);

  logic [WIDTH-1:0] DATA_IN;
  logic             DATA_VALID;
  logic             DATA_READY;
  logic [WIDTH-1:0] SERDES_D;
  logic             LOAD_WORD;
  logic             SERDES_RST;
  logic             LINK_UP;
  logic [7:0]       UNDERRUN_CNT;

  // User side: supplies words, observes SERDES controls and status.
  modport master (
    output DATA_IN,
    output DATA_VALID,
    input  DATA_READY,
    input  SERDES_D,
    input  LOAD_WORD,
    input  SERDES_RST,
    input  LINK_UP,
    input  UNDERRUN_CNT
  );

  // Controller side.
  modport slave (
    input  DATA_IN,
    input  DATA_VALID,
    output DATA_READY,
    output SERDES_D,
    output LOAD_WORD,
    output SERDES_RST,
    output LINK_UP,
    output UNDERRUN_CNT
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, synchronous reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/oserdes_load_ctrl.sv
// O_SERDES bring-up and word-load controller: waits for stable PLL lock, pulses
// the SERDES reset, then feeds one word per load period from a 1-entry buffer.
module oserdes_load_ctrl
  import oserdes_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH       = 4,
  parameter int unsigned      LOCK_SETTLE = 16,
  parameter int unsigned      RST_CYCLES  = 4,
  parameter int unsigned      LOAD_PERIOD = 2,
  parameter logic [WIDTH-1:0] IDLE_WORD   = '0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                PLL_LOCK,
  oserdes_load_ctrl_if.slave  bus
);

  localparam logic [SettleCntW-1:0] SettleLast = SettleCntW'(LOCK_SETTLE - 1);
  localparam logic [RstCntW-1:0]    RstLast    = RstCntW'(RST_CYCLES - 1);
  localparam logic [PeriodCntW-1:0] PeriodLast = PeriodCntW'(LOAD_PERIOD - 1);

  logic lock;

  sync_2ff u_lock_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (PLL_LOCK),
    .q_o   (lock)
  );

  state_t                state_q, state_d;
  logic [SettleCntW-1:0] settle_cnt_q, settle_cnt_d;
  logic [RstCntW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [PeriodCntW-1:0] period_cnt_q, period_cnt_d;
  logic [WIDTH-1:0]      hold_q, hold_d;
  logic                  full_q, full_d;
  logic [WIDTH-1:0]      serdes_d_q, serdes_d_d;
  logic                  load_q, load_d;
  logic [UnderrunW-1:0]  underrun_q, underrun_d;

  logic run;
  logic slot;
  logic slot_fire;
  logic ready;
  logic accept;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    unique case (state_q)
      StWaitLock: begin
        if (lock) begin
          state_d      = StSettle;
          settle_cnt_d = '0;
        end
      end
      StSettle: begin
        if (!lock) begin
          state_d = StWaitLock;
        end else if (settle_cnt_q == SettleLast) begin
          state_d   = StSrst;
          rst_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      StSrst: begin
        if (!lock) begin
          state_d = StWaitLock;
        end else if (rst_cnt_q == RstLast) begin
          state_d = StRun;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!lock) begin
          state_d = StWaitLock;
        end
      end
      default: state_d = StWaitLock;
    endcase
  end

  assign run       = (state_q == StRun);
  assign slot      = run && (period_cnt_q == PeriodLast);
  // A slot coinciding with lock loss is dropped; the link is going down anyway.
  assign slot_fire = slot && lock;
  assign ready     = run && (!full_q || slot);
  assign accept    = bus.DATA_VALID && ready;

  always_comb begin
    period_cnt_d = '0;
    if (run && lock && !slot) begin
      period_cnt_d = period_cnt_q + 1'b1;
    end

    hold_d     = hold_q;
    full_d     = full_q;
    serdes_d_d = serdes_d_q;
    load_d     = slot_fire;
    underrun_d = underrun_q;

    if (slot_fire) begin
      serdes_d_d = full_q ? hold_q : IDLE_WORD;
      full_d     = 1'b0;
      if (!full_q) begin
        underrun_d = sat_inc(underrun_q);
      end
    end

    // Accept after consume so a slot-cycle transfer refills the emptied entry.
    if (accept) begin
      hold_d = bus.DATA_IN;
      full_d = 1'b1;
    end

    if (!lock) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StWaitLock;
      settle_cnt_q <= '0;
      rst_cnt_q    <= '0;
      period_cnt_q <= '0;
      hold_q       <= IDLE_WORD;
      full_q       <= 1'b0;
      serdes_d_q   <= IDLE_WORD;
      load_q       <= 1'b0;
      underrun_q   <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      period_cnt_q <= period_cnt_d;
      hold_q       <= hold_d;
      full_q       <= full_d;
      serdes_d_q   <= serdes_d_d;
      load_q       <= load_d;
      underrun_q   <= underrun_d;
    end
  end

  assign bus.DATA_READY   = ready;
  assign bus.SERDES_D     = serdes_d_q;
  assign bus.LOAD_WORD    = load_q;
  assign bus.SERDES_RST   = !run;
  assign bus.LINK_UP      = run;
  assign bus.UNDERRUN_CNT = underrun_q;

endmodule

// File: tb/tb_oserdes_load_ctrl.sv
// Directed bench: bring-up timing, streaming, underrun saturation, lock glitch,
// lock loss flush, and mid-RUN reset with a continuous-load instance.
module tb_oserdes_load_ctrl;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, lock_a, lock_b;

  oserdes_load_ctrl_if #(.WIDTH(W)) a_if ();
  oserdes_load_ctrl_if #(.WIDTH(W)) b_if ();

  oserdes_load_ctrl #(
    .WIDTH       (W),
    .LOCK_SETTLE (16),
    .RST_CYCLES  (4),
    .LOAD_PERIOD (2),
    .IDLE_WORD   (4'h0)
  ) u_dut_a (
    .CLK      (clk),
    .RST      (rst_a),
    .PLL_LOCK (lock_a),
    .bus      (a_if.slave)
  );

  oserdes_load_ctrl #(
    .WIDTH       (W),
    .LOCK_SETTLE (16),
    .RST_CYCLES  (4),
    .LOAD_PERIOD (1),
    .IDLE_WORD   (4'h0)
  ) u_dut_b (
    .CLK      (clk),
    .RST      (rst_b),
    .PLL_LOCK (lock_b),
    .bus      (b_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] words [3];
  int  a_fall, b_fall, a_first, b_first;
  int  ld_idx, wr_idx, last_ld, empty, zero_bad, cnt_bad, ready_viol, hi, exp_cnt;
  bit  fire, found;

  initial begin
    words      = '{4'h1, 4'h2, 4'h3};
    a_fall     = -1;
    b_fall     = -1;
    a_first    = -1;
    b_first    = -1;
    ld_idx     = 0;
    wr_idx     = 0;
    last_ld    = 0;
    empty      = 0;
    zero_bad   = 0;
    cnt_bad    = 0;
    ready_viol = 0;

    rst_a = 1'b1;
    rst_b = 1'b1;
    lock_a = 1'b1;
    lock_b = 1'b1;
    a_if.DATA_VALID = 1'b1;
    a_if.DATA_IN    = words[0];
    b_if.DATA_VALID = 1'b0;
    b_if.DATA_IN    = 4'h0;
    repeat (3) tick();

    check_eq("rst_ready",      a_if.DATA_READY,   0);
    check_eq("rst_serdes_d",   a_if.SERDES_D,     0);
    check_eq("rst_load_word",  a_if.LOAD_WORD,    0);
    check_eq("rst_serdes_rst", a_if.SERDES_RST,   1);
    check_eq("rst_link_up",    a_if.LINK_UP,      0);
    check_eq("rst_underrun",   a_if.UNDERRUN_CNT, 0);

    rst_a = 1'b0;
    rst_b = 1'b0;

    // Bring-up, stream 1,2,3, then idle until 300 empty slots have loaded.
    for (int k = 0; k < 800 && empty < 300; k++) begin
      fire = a_if.DATA_VALID && a_if.DATA_READY;
      tick();
      if (a_fall < 0 && !a_if.SERDES_RST) begin
        a_fall = k;
        check_eq("a_link_up_at_fall", a_if.LINK_UP, 1);
      end
      if (b_fall < 0 && !b_if.SERDES_RST) b_fall = k;
      if (a_if.SERDES_RST && a_if.DATA_READY) ready_viol++;
      if (b_first < 0 && b_if.LOAD_WORD) b_first = k;
      if (a_if.LOAD_WORD) begin
        if (a_first < 0) a_first = k;
        if (ld_idx < 3) begin
          check_eq($sformatf("stream_word%0d", ld_idx), a_if.SERDES_D, words[ld_idx]);
          if (ld_idx > 0) check_eq("stream_gap", k - last_ld, 2);
          if (ld_idx == 2) check_eq("stream_underrun", a_if.UNDERRUN_CNT, 0);
          last_ld = k;
          ld_idx++;
        end else begin
          empty++;
          exp_cnt = (empty > 255) ? 255 : empty;
          if (a_if.SERDES_D != 4'h0) zero_bad++;
          if (a_if.UNDERRUN_CNT != 8'(exp_cnt)) cnt_bad++;
        end
      end
      if (fire) begin
        wr_idx++;
        if (wr_idx < 3) a_if.DATA_IN = words[wr_idx];
        else a_if.DATA_VALID = 1'b0;
      end
    end

    check_eq("a_serdes_rst_fall", a_fall, 22);
    check_eq("b_serdes_rst_fall", b_fall, 22);
    check_eq("a_first_load", a_first, 24);
    check_eq("b_first_load", b_first, 23);
    check_eq("stream_loads", ld_idx, 3);
    check_eq("ready_outside_run", ready_viol, 0);
    check_eq("idle_slots_seen", empty, 300);
    check_eq("idle_word_loads", zero_bad, 0);
    check_eq("underrun_model", cnt_bad, 0);
    check_eq("underrun_sat", a_if.UNDERRUN_CNT, 255);

    // Lock loss with a word held, then relock with fresh data.
    a_if.DATA_VALID = 1'b1;
    a_if.DATA_IN    = 4'hA;
    repeat (4) tick();
    lock_a = 1'b0;
    found  = 1'b0;
    for (int i = 0; i < 3 && !found; i++) begin
      tick();
      if (a_if.SERDES_RST) found = 1'b1;
    end
    check_eq("drop_serdes_rst", found, 1);
    check_eq("drop_link_up", a_if.LINK_UP, 0);
    check_eq("drop_ready", a_if.DATA_READY, 0);

    a_if.DATA_VALID = 1'b0;
    a_if.DATA_IN    = 4'hB;
    lock_a = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (a_if.LINK_UP) found = 1'b1;
    end
    check_eq("relock_link_up", found, 1);
    a_if.DATA_VALID = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (a_if.LOAD_WORD) found = 1'b1;
    end
    check_eq("relock_load_seen", found, 1);
    check_eq("relock_first_word", a_if.SERDES_D, 4'hB);
    a_if.DATA_VALID = 1'b0;

    // Lock glitch of 3 cycles while the settle count is 10.
    rst_a = 1'b1;
    repeat (2) tick();
    rst_a  = 1'b0;
    a_fall = -1;
    for (int k = 0; k < 60 && a_fall < 0; k++) begin
      tick();
      if (!a_if.SERDES_RST) a_fall = k;
      if (k == 10) lock_a = 1'b0;
      if (k == 13) lock_a = 1'b1;
    end
    check_eq("glitch_serdes_rst_fall", a_fall, 36);

    // Continuous loads with LOAD_PERIOD=1, then reset mid-RUN with a word held.
    b_if.DATA_VALID = 1'b1;
    b_if.DATA_IN    = 4'h5;
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (b_if.LOAD_WORD) hi++;
    end
    check_eq("b_load_continuous", hi, 5);
    check_eq("b_load_data", b_if.SERDES_D, 4'h5);
    check_eq("b_underrun_pre_rst", b_if.UNDERRUN_CNT, 255);

    rst_b = 1'b1;
    tick();
    check_eq("b_rst_ready",      b_if.DATA_READY,   0);
    check_eq("b_rst_serdes_d",   b_if.SERDES_D,     0);
    check_eq("b_rst_load_word",  b_if.LOAD_WORD,    0);
    check_eq("b_rst_serdes_rst", b_if.SERDES_RST,   1);
    check_eq("b_rst_link_up",    b_if.LINK_UP,      0);
    check_eq("b_rst_underrun",   b_if.UNDERRUN_CNT, 0);
    rst_b = 1'b0;
    b_if.DATA_VALID = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (b_if.LOAD_WORD) found = 1'b1;
    end
    check_eq("b_after_rst_load_seen", found, 1);
    check_eq("b_after_rst_word", b_if.SERDES_D, 4'h0);
    check_eq("b_after_rst_underrun", b_if.UNDERRUN_CNT, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
